// File: rtl/sm_debug_ctrl.sv
// rtl/sm_debug_ctrl.sv - debug run/halt/step controller with 32-word register dump port
module sm_debug_ctrl #(
    parameter bit RESET_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    input  logic        bp_hit,
    output logic        cpu_en,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_addr,
    output logic [31:0] dump_data,
    output logic        dump_last,
    output logic [2:0]  status
);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_HALT      = 3'd1,
        S_STEP      = 3'd2,
        S_DUMP_RD   = 3'd3,
        S_DUMP_WAIT = 3'd4
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  dump_addr_q, dump_addr_d;
    logic [31:0] dump_data_q, dump_data_d;
    logic        dump_valid_q, dump_valid_d;
    logic        accept;

    assign cmd_ready  = (state_q == S_RUN) || (state_q == S_HALT);
    assign accept     = cmd_valid && cmd_ready;
    assign cpu_en     = (state_q == S_STEP) || ((state_q == S_RUN) && !bp_hit);
    assign regAddr    = ((state_q == S_DUMP_RD) || (state_q == S_DUMP_WAIT)) ? idx_q : 5'd0;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_valid_q && (dump_addr_q == 5'd31);
    assign status     = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        case (state_q)
            S_RUN, S_HALT: begin
                if (accept) begin
                    case (cmd_op)
                        // a breakpoint still wins over a RUN issued while already running
                        OP_RUN:  state_d = (state_q == S_RUN && bp_hit) ? S_HALT : S_RUN;
                        OP_HALT: state_d = S_HALT;
                        OP_STEP: begin
                            cnt_d   = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
                            state_d = S_STEP;
                        end
                        OP_DUMP: begin
                            idx_d   = 5'd0;
                            state_d = S_DUMP_RD;
                        end
                        default: state_d = S_HALT;
                    endcase
                end else if (state_q == S_RUN && bp_hit) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_HALT;
                end
            end
            S_DUMP_RD: begin
                dump_data_d  = regData;
                dump_addr_d  = idx_q;
                dump_valid_d = 1'b1;
                state_d      = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    if (idx_q == 5'd31) begin
                        state_d = S_HALT;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_RUN ? S_RUN : S_HALT;
            cnt_q        <= 8'd0;
            idx_q        <= 5'd0;
            dump_addr_q  <= 5'd0;
            dump_data_q  <= 32'd0;
            dump_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
        end
    end

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// tb/tb_sm_debug_ctrl.sv - scoreboard bench for sm_debug_ctrl with a small CPU register model
module tb_sm_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_arg = 8'd0;
    logic        bp_hit = 1'b0;
    logic        cpu_en;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_last;
    logic [2:0]  status;

    logic [31:0] rf [32];
    logic [31:0] pc = 32'd0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_val = 32'd0;
    logic        rdy_rand = 1'b0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    sm_debug_ctrl #(.RESET_RUN(1'b0)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .bp_hit(bp_hit), .cpu_en(cpu_en),
        .regAddr(regAddr), .regData(regData),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_last(dump_last), .status(status)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    end

    assign regData = (regAddr == 5'd0) ? pc : rf[regAddr];

    always @(posedge clk) begin
        if (pc_load) pc <= pc_val;
        else if (cpu_en) pc <= pc + 32'd1;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) dump_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks held data while stalled and pops the scoreboard on each handshake
    logic        hold_prev = 1'b0;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;
    always @(negedge clk) begin
        if (dump_valid) begin
            if (hold_prev) begin
                chk("hold_addr", {27'd0, dump_addr}, {27'd0, hold_a});
                chk("hold_data", dump_data, hold_d);
            end
            if (dump_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dump_addr", {27'd0, dump_addr}, {27'd0, e.a});
                    chk("dump_data", dump_data, e.d);
                    chk("dump_last", {31'd0, dump_last}, {31'd0, (e.a == 5'd31)});
                end
                hold_prev = 1'b0;
            end else begin
                hold_prev = 1'b1;
                hold_a    = dump_addr;
                hold_d    = dump_data;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_dump(input logic [31:0] pc0);
        for (int i = 0; i < 32; i++) begin
            exp_t e;
            e.a = 5'(i);
            e.d = (i == 0) ? pc0 : (32'h100 + 32'(i));
            exp_q.push_back(e);
        end
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_load = 1'b1;
        pc_val  = v;
        @(posedge clk); #1;
        pc_load = 1'b0;
    endtask

    task automatic wait_dump_done(input string name);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && status == 3'd1) && k < 800) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, {31'd0, (k < 800)}, 32'd1);
    endtask

    task automatic count_step(input string name, input int exp_n);
        int n;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (cpu_en) n++;
        end
        @(posedge clk); #1;
        chk(name, 32'(n), 32'(exp_n));
        chk({name, "_status"}, {29'd0, status}, 32'd1);
    endtask

    initial begin
        logic [31:0] pc_before;
        logic [31:0] pc_frozen;
        int          k;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_status", {29'd0, status}, 32'd1);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
        chk("rst_regaddr", {27'd0, regAddr}, 32'd0);
        chk("rst_dump_last", {31'd0, dump_last}, 32'd0);

        // STEP 3 and STEP 0
        load_pc(32'h0);
        send_cmd(2'b10, 8'd3);
        count_step("step3_cycles", 3);
        chk("step3_pc", pc, 32'd3);
        send_cmd(2'b10, 8'd0);
        count_step("step0_cycles", 1);
        chk("step0_pc", pc, 32'd4);

        // HALT ignores breakpoints
        bp_hit = 1'b1;
        @(posedge clk); #1;
        bp_hit = 1'b0;
        chk("halt_bp_ignored", {29'd0, status}, 32'd1);

        // RUN then single-cycle breakpoint
        send_cmd(2'b00, 8'd0);
        chk("run_status", {29'd0, status}, 32'd0);
        chk("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        bp_hit = 1'b1;
        @(negedge clk);
        chk("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
        @(posedge clk); #1;
        bp_hit = 1'b0;
        chk("bp_halt", {29'd0, status}, 32'd1);

        // RUN accepted from RUN with bp_hit set lands in HALT
        send_cmd(2'b00, 8'd0);
        bp_hit = 1'b1;
        send_cmd(2'b00, 8'd0);
        bp_hit = 1'b0;
        chk("run_bp_halt", {29'd0, status}, 32'd1);

        // DUMP from HALT with random back-pressure
        load_pc(32'h40);
        push_dump(32'h40);
        rdy_rand = 1'b1;
        send_cmd(2'b11, 8'd0);
        chk("dump_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        wait_dump_done("dump1_done");
        chk("dump1_pc", pc, 32'h40);

        // DUMP issued while running
        send_cmd(2'b00, 8'd0);
        repeat (3) @(posedge clk);
        #1 pc_before = pc;
        send_cmd(2'b11, 8'd0);
        pc_frozen = pc;
        chk("dump2_acc_pc", pc_frozen, pc_before + 32'd1);
        push_dump(pc_frozen);
        @(negedge clk);
        chk("dump2_cpu_en", {31'd0, cpu_en}, 32'd0);
        wait_dump_done("dump2_done");
        chk("dump2_pc", pc, pc_frozen);
        chk("dump2_status", {29'd0, status}, 32'd1);

        // Reset in DUMP_WAIT at index 10
        rdy_rand   = 1'b0;
        dump_ready = 1'b1;
        load_pc(32'h55);
        push_dump(32'h55);
        send_cmd(2'b11, 8'd0);
        k = 0;
        while (!(status == 3'd4 && dump_addr == 5'd10) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_idx10", {31'd0, (k < 200)}, 32'd1);
        dump_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_dump_valid", {31'd0, dump_valid}, 32'd0);
        chk("abort_status", {29'd0, status}, 32'd1);
        chk("abort_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("abort_remaining", 32'(exp_q.size()), 32'd22);
        exp_q.delete();

        // Fresh dump restarts at index 0
        load_pc(32'h77);
        push_dump(32'h77);
        rdy_rand = 1'b1;
        send_cmd(2'b11, 8'd0);
        wait_dump_done("dump3_done");
        rdy_rand = 1'b0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
